join_logic_op: RTL and testbench

- Parametrised successor to the single-cycle two-operand AND dataflow node.
- Pairs tokens from two independent input streams through per-operand FIFOs, so operands no longer need to arrive in the same cycle.
- Applies a runtime-selectable bitwise operation to each pair and emits one result token per pair.
- Sits between dataflow producers and consumers in the operator graph.

---
 rtl/join_logic_op.sv | 126 ++++++++++++
 tb/tb_join_logic_op.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/join_logic_op.sv
// rtl/join_logic_op.sv - two-stream join node with per-operand FIFOs and selectable bitwise op
//
// Purpose: queues operand-1 and operand-2 tokens in independent FIFOs, pairs the
// heads whenever both are present and emits f(OP, head1, head2) as one result token.
//
// Ports:
//   CLK    - clock, rising edge
//   RST    - asynchronous active-low reset
//   EN     - global enable; gates every push and pop
//   OP     - operation select, sampled in the pop cycle
//   R_IN1  - operand-1 token valid      D_IN1 - operand-1 data
//   FULL1  - operand-1 FIFO full
//   R_IN2  - operand-2 token valid      D_IN2 - operand-2 data
//   FULL2  - operand-2 FIFO full
//   R_OUT  - one-cycle result pulse     D_OUT - result data, held between tokens
//   OVF    - sticky overflow flags, bit0 operand 1, bit1 operand 2

module join_logic_op #(
    parameter  int N     = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [2:0]   OP,
    input  logic         R_IN1,
    input  logic [N-1:0] D_IN1,
    output logic         FULL1,
    input  logic         R_IN2,
    input  logic [N-1:0] D_IN2,
    output logic         FULL2,
    output logic         R_OUT,
    output logic [N-1:0] D_OUT,
    output logic [1:0]   OVF
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [N-1:0]  r_mem1 [DEPTH];
    logic [N-1:0]  r_mem2 [DEPTH];
    logic [AW-1:0] r_wp1, r_rp1, r_wp2, r_rp2;
    logic [AW:0]   r_cnt1, r_cnt2;

    logic          w_pop;
    logic          w_push1, w_push2;
    logic          w_drop1, w_drop2;
    logic [N-1:0]  w_head1, w_head2;
    logic [N-1:0]  w_result;

    assign FULL1 = (r_cnt1 == CNT_FULL);
    assign FULL2 = (r_cnt2 == CNT_FULL);

    // Pop decision uses pre-edge counts only; a token pushed this edge waits a cycle.
    assign w_pop = EN && (r_cnt1 != '0) && (r_cnt2 != '0);

    // A full FIFO still accepts a push when its head leaves in the same edge.
    assign w_push1 = EN && R_IN1 && (!FULL1 || w_pop);
    assign w_push2 = EN && R_IN2 && (!FULL2 || w_pop);
    assign w_drop1 = EN && R_IN1 && FULL1 && !w_pop;
    assign w_drop2 = EN && R_IN2 && FULL2 && !w_pop;

    assign w_head1 = r_mem1[r_rp1];
    assign w_head2 = r_mem2[r_rp2];

    always_comb begin
        w_result = '0;
        case (OP)
            3'd0:    w_result = w_head1 & w_head2;
            3'd1:    w_result = w_head1 | w_head2;
            3'd2:    w_result = w_head1 ^ w_head2;
            3'd3:    w_result = ~(w_head1 & w_head2);
            3'd4:    w_result = ~(w_head1 | w_head2);
            3'd5:    w_result = ~(w_head1 ^ w_head2);
            3'd6:    w_result = w_head1 & ~w_head2;
            default: w_result = w_head1;
        endcase
    end

    // Storage carries no reset: stale entries are unreachable once counts clear.
    always_ff @(posedge CLK) begin
        if (w_push1) r_mem1[r_wp1] <= D_IN1;
        if (w_push2) r_mem2[r_wp2] <= D_IN2;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wp1  <= '0;
            r_rp1  <= '0;
            r_cnt1 <= '0;
            r_wp2  <= '0;
            r_rp2  <= '0;
            r_cnt2 <= '0;
            R_OUT  <= 1'b0;
            D_OUT  <= '0;
            OVF    <= '0;
        end else begin
            if (w_push1) r_wp1 <= r_wp1 + PTR_ONE;
            if (w_push2) r_wp2 <= r_wp2 + PTR_ONE;
            if (w_pop) begin
                r_rp1 <= r_rp1 + PTR_ONE;
                r_rp2 <= r_rp2 + PTR_ONE;
            end

            case ({w_push1, w_pop})
                2'b10:   r_cnt1 <= r_cnt1 + CNT_ONE;
                2'b01:   r_cnt1 <= r_cnt1 - CNT_ONE;
                default: r_cnt1 <= r_cnt1;
            endcase
            case ({w_push2, w_pop})
                2'b10:   r_cnt2 <= r_cnt2 + CNT_ONE;
                2'b01:   r_cnt2 <= r_cnt2 - CNT_ONE;
                default: r_cnt2 <= r_cnt2;
            endcase

            R_OUT <= w_pop;
            if (w_pop) D_OUT <= w_result;

            if (w_drop1) OVF[0] <= 1'b1;
            if (w_drop2) OVF[1] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_join_logic_op.sv
// tb/tb_join_logic_op.sv - self-checking bench for join_logic_op

module tb_join_logic_op;

    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         EN = 1'b0;
    logic [2:0]   OP = '0;
    logic         R_IN1 = 1'b0;
    logic [N-1:0] D_IN1 = '0;
    logic         FULL1;
    logic         R_IN2 = 1'b0;
    logic [N-1:0] D_IN2 = '0;
    logic         FULL2;
    logic         R_OUT;
    logic [N-1:0] D_OUT;
    logic [1:0]   OVF;

    join_logic_op #(.N(N), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .OP(OP),
        .R_IN1(R_IN1), .D_IN1(D_IN1), .FULL1(FULL1),
        .R_IN2(R_IN2), .D_IN2(D_IN2), .FULL2(FULL2),
        .R_OUT(R_OUT), .D_OUT(D_OUT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // reference state: operand queues plus expected outputs
    logic [N-1:0] q1[$];
    logic [N-1:0] q2[$];
    logic         m_rout = 1'b0;
    logic [N-1:0] m_dout = '0;
    logic [1:0]   m_ovf  = '0;

    logic [N-1:0] sweep_exp [8] = '{16'h8888, 16'hEEEE, 16'h6666, 16'h7777,
                                    16'h1111, 16'h9999, 16'h2222, 16'hAAAA};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] ref_op(input int op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return ~(a ^ b);
            6: return a & ~b;
            default: return a;
        endcase
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".rout"}, 32'(R_OUT), 32'(m_rout));
        chk({tag, ".dout"}, 32'(D_OUT), 32'(m_dout));
        chk({tag, ".full1"}, 32'(FULL1), 32'(q1.size() == DEPTH));
        chk({tag, ".full2"}, 32'(FULL2), 32'(q2.size() == DEPTH));
        chk({tag, ".ovf"}, 32'(OVF), 32'(m_ovf));
    endtask

    // drive one cycle, advance the model by the spec rules, then compare after the edge
    task automatic cyc(input string tag, input logic en, input int op,
                       input logic r1, input logic [N-1:0] d1,
                       input logic r2, input logic [N-1:0] d2);
        logic [N-1:0] a, b;
        EN = en; OP = op[2:0]; R_IN1 = r1; D_IN1 = d1; R_IN2 = r2; D_IN2 = d2;
        m_rout = 1'b0;
        if (en && q1.size() > 0 && q2.size() > 0) begin
            a = q1.pop_front();
            b = q2.pop_front();
            m_dout = ref_op(op, a, b);
            m_rout = 1'b1;
        end
        if (en && r1) begin
            if (q1.size() < DEPTH) q1.push_back(d1);
            else m_ovf[0] = 1'b1;
        end
        if (en && r2) begin
            if (q2.size() < DEPTH) q2.push_back(d2);
            else m_ovf[1] = 1'b1;
        end
        @(posedge CLK);
        #1;
        check_outs(tag);
    endtask

    task automatic idle(input string tag, input int op);
        cyc(tag, 1'b1, op, 1'b0, '0, 1'b0, '0);
    endtask

    // reset lands between edges; outputs must clear without waiting for a clock
    task automatic async_reset(input string tag);
        #2;
        RST = 1'b0;
        #1;
        q1.delete();
        q2.delete();
        m_rout = 1'b0;
        m_dout = '0;
        m_ovf  = '0;
        check_outs(tag);
        EN = 1'b0; R_IN1 = 1'b0; R_IN2 = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #12;
        check_outs("reset");
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // same-cycle pair
        cyc("pair0", 1'b1, 0, 1'b1, 16'hF0F0, 1'b1, 16'h3C3C);
        idle("pair1", 0);
        chk("pair_val", 32'(D_OUT), 32'h3030);
        idle("pair2", 0);
        chk("pair_hold", 32'(D_OUT), 32'h3030);

        // skewed arrival
        cyc("skew0", 1'b1, 2, 1'b1, 16'h00FF, 1'b0, '0);
        idle("skew1", 2);
        idle("skew2", 2);
        cyc("skew3", 1'b1, 2, 1'b0, '0, 1'b1, 16'h0F0F);
        idle("skew4", 2);
        chk("skew_val", 32'(D_OUT), 32'h0FF0);

        // op sweep
        for (int k = 0; k < 8; k++) begin
            cyc("sweep_push", 1'b1, k, 1'b1, 16'hAAAA, 1'b1, 16'hCCCC);
            idle("sweep_pop", k);
            chk("sweep_tbl", 32'(D_OUT), 32'(sweep_exp[k]));
        end

        // EN dropped mid-stream
        for (int k = 0; k < 3; k++)
            cyc("en_a", 1'b1, 1, 1'b1, 16'(k + 16'h10), 1'b1, 16'(k + 16'h20));
        cyc("en_off0", 1'b0, 1, 1'b1, 16'h5555, 1'b1, 16'h5555);
        cyc("en_off1", 1'b0, 1, 1'b1, 16'h6666, 1'b1, 16'h6666);
        for (int k = 0; k < 3; k++) idle("en_drain", 1);

        // overflow on channel 1, then drain with pass-A
        async_reset("rst_a");
        for (int k = 1; k <= 5; k++) begin
            cyc("ovf_push", 1'b1, 7, 1'b1, 16'(k), 1'b0, '0);
            if (k == 4) chk("ovf_full4", 32'(FULL1), 32'h1);
        end
        chk("ovf_flag", 32'(OVF), 32'h1);
        cyc("ovf_b0", 1'b1, 7, 1'b0, '0, 1'b1, 16'hFFFF);
        for (int k = 1; k <= 4; k++) begin
            cyc("ovf_b", 1'b1, 7, 1'b0, '0, 1'b1, 16'hFFFF);
            chk("ovf_order", 32'(D_OUT), 32'(k));
        end
        idle("ovf_end", 7);

        // full channel 1 with concurrent push+pop: count held, no overflow
        async_reset("rst_b");
        for (int k = 0; k < DEPTH; k++) cyc("fill", 1'b1, 0, 1'b1, 16'(k + 1), 1'b0, '0);
        cyc("fill_b", 1'b1, 0, 1'b0, '0, 1'b1, 16'hFFFF);
        for (int k = 0; k < 8; k++)
            cyc("full_pp", 1'b1, 1, 1'b1, 16'(16'h100 + k), 1'b1, 16'h0);

        // reset with queued entries
        cyc("pre_rst0", 1'b1, 0, 1'b1, 16'h1234, 1'b0, '0);
        cyc("pre_rst1", 1'b1, 0, 1'b1, 16'h5678, 1'b0, '0);
        async_reset("rst_c");
        cyc("post_rst0", 1'b1, 7, 1'b1, 16'hBEEF, 1'b1, 16'h0000);
        idle("post_rst1", 7);
        chk("post_rst_val", 32'(D_OUT), 32'hBEEF);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            cyc("rand", ($urandom_range(0, 9) != 0), int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0), 16'($urandom),
                ($urandom_range(0, 3) < 2), 16'($urandom));
            if (k % 200 == 199) async_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
